// File: rtl/timing_fsm_pkg.sv
// rtl/timing_fsm_pkg.sv - bank state codes, default timings and command priority (ROWCLONE_EN)
package timing_fsm_pkg;

    typedef enum logic [4:0] {
        ST_IDLE         = 5'd0,
        ST_ACTIVATING   = 5'd1,
        ST_BANK_ACTIVE  = 5'd2,
        ST_READING      = 5'd3,
        ST_READING_AP   = 5'd4,
        ST_WRITING      = 5'd5,
        ST_WRITING_AP   = 5'd6,
        ST_PRECHARGING  = 5'd7,
        ST_REFRESHING   = 5'd8,
        ST_POWER_DOWN   = 5'd9,
        ST_ACTIVE_PD    = 5'd10,
        ST_SELF_REFRESH = 5'd11,
        ST_DEEP_PD      = 5'd12
    } bank_state_t;

    localparam int DEF_BL    = 8;
    localparam int DEF_T_RCD = 15;
    localparam int DEF_T_RP  = 16;
    localparam int DEF_T_RFC = 34;
    localparam int DEF_T_WR  = 14;

    // Lower code = higher priority; CMD_NONE sits at bit 0 of the request vector.
    typedef enum logic [3:0] {
        CMD_NONE, CMD_PRA, CMD_PR, CMD_BST, CMD_RDA, CMD_RD, CMD_WRA, CMD_WR,
        CMD_ACT, CMD_REF, CMD_SRF, CMD_PD, CMD_PDX, CMD_CKEH, CMD_DPD, CMD_DPDX
    } cmd_t;

    localparam int NUM_CMD = 16;

    function automatic logic cmd_legal(input cmd_t c, input bank_state_t s, input logic all_idle);
        case (c)
            CMD_PRA, CMD_PR, CMD_RDA, CMD_RD, CMD_WRA, CMD_WR:
                return s == ST_BANK_ACTIVE;
            CMD_BST:  return (s == ST_READING) || (s == ST_WRITING);
`ifdef ROWCLONE_EN
            CMD_ACT:  return (s == ST_IDLE) || (s == ST_BANK_ACTIVE) || (s == ST_WRITING_AP);
`else
            CMD_ACT:  return s == ST_IDLE;
`endif
            CMD_REF, CMD_SRF, CMD_DPD:
                return all_idle;
            CMD_PD:   return (s == ST_IDLE) || (s == ST_BANK_ACTIVE);
            CMD_PDX:  return (s == ST_POWER_DOWN) || (s == ST_ACTIVE_PD);
            CMD_CKEH: return s == ST_SELF_REFRESH;
            CMD_DPDX: return s == ST_DEEP_PD;
            default:  return 1'b0;
        endcase
    endfunction

    // Scan low priority to high so the last legal hit is the winner.
    function automatic cmd_t pick_cmd(input logic [NUM_CMD-1:0] req, input bank_state_t s,
                                      input logic all_idle);
        cmd_t c;
        cmd_t win;
        win = CMD_NONE;
        for (int i = NUM_CMD - 1; i >= 1; i--) begin
            c = cmd_t'(4'(i));
            if (req[i] && cmd_legal(c, s, all_idle)) win = c;
        end
        return win;
    endfunction

endpackage

// File: rtl/timing_fsm_bank.sv
// rtl/timing_fsm_bank.sv - single-bank state register, duration counter and next-state logic
module bank_fsm
    import timing_fsm_pkg::*;
#(
    parameter int BL    = DEF_BL,
    parameter int T_RCD = DEF_T_RCD,
    parameter int T_RP  = DEF_T_RP,
    parameter int T_RFC = DEF_T_RFC,
    parameter int T_WR  = DEF_T_WR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_CMD-1:0] req,
    input  logic               all_idle,
    output bank_state_t        state
);

    localparam int T_MAX = (T_RFC > T_RP) ? ((T_RFC > T_RCD) ? ((T_RFC > T_WR) ? ((T_RFC > BL) ? T_RFC : BL)
                         : ((T_WR > BL) ? T_WR : BL)) : ((T_RCD > T_WR) ? ((T_RCD > BL) ? T_RCD : BL)
                         : ((T_WR > BL) ? T_WR : BL))) : ((T_RP > T_RCD) ? ((T_RP > T_WR) ? ((T_RP > BL) ? T_RP : BL)
                         : ((T_WR > BL) ? T_WR : BL)) : ((T_RCD > T_WR) ? ((T_RCD > BL) ? T_RCD : BL)
                         : ((T_WR > BL) ? T_WR : BL)));
    localparam int CW = (T_MAX > 2) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
    localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
    localparam logic [CW-1:0] L_RFC = CW'(T_RFC - 1);
    localparam logic [CW-1:0] L_WR  = CW'(T_WR - 1);
    localparam logic [CW-1:0] L_BL  = CW'(BL - 1);

    bank_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;
    cmd_t          sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Expiry of a timed state takes precedence; commands only land when no expiry happens.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        sel     = pick_cmd(req, state_q, all_idle);
        case (state_q)
            ST_ACTIVATING, ST_READING, ST_WRITING: begin
                if (cnt_q == '0) state_d = ST_BANK_ACTIVE;
                else begin cnt_d = cnt_q - 1'b1; take = 1'b1; end
            end
            ST_READING_AP, ST_WRITING_AP: begin
                if (cnt_q == '0) begin state_d = ST_PRECHARGING; cnt_d = L_RP; end
                else begin cnt_d = cnt_q - 1'b1; take = 1'b1; end
            end
            ST_PRECHARGING, ST_REFRESHING: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else begin cnt_d = cnt_q - 1'b1; take = 1'b1; end
            end
            ST_IDLE, ST_BANK_ACTIVE, ST_POWER_DOWN, ST_ACTIVE_PD, ST_SELF_REFRESH, ST_DEEP_PD:
                take = 1'b1;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (take) begin
            case (sel)
                CMD_PRA, CMD_PR: begin state_d = ST_PRECHARGING; cnt_d = L_RP;  end
                CMD_BST:         begin state_d = ST_BANK_ACTIVE; cnt_d = '0;    end
                CMD_RDA:         begin state_d = ST_READING_AP;  cnt_d = L_BL;  end
                CMD_RD:          begin state_d = ST_READING;     cnt_d = L_BL;  end
                CMD_WRA:         begin state_d = ST_WRITING_AP;  cnt_d = L_WR;  end
                CMD_WR:          begin state_d = ST_WRITING;     cnt_d = L_WR;  end
                CMD_ACT:         begin state_d = ST_ACTIVATING;  cnt_d = L_RCD; end
                CMD_REF:         begin state_d = ST_REFRESHING;  cnt_d = L_RFC; end
                CMD_SRF:         begin state_d = ST_SELF_REFRESH; cnt_d = '0;   end
                CMD_PD: begin
                    state_d = (state_q == ST_BANK_ACTIVE) ? ST_ACTIVE_PD : ST_POWER_DOWN;
                    cnt_d   = '0;
                end
                CMD_PDX: begin
                    state_d = (state_q == ST_ACTIVE_PD) ? ST_BANK_ACTIVE : ST_IDLE;
                    cnt_d   = '0;
                end
                CMD_CKEH, CMD_DPDX: begin state_d = ST_IDLE; cnt_d = '0; end
                CMD_DPD:         begin state_d = ST_DEEP_PD;     cnt_d = '0;    end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/timing_fsm.sv
// rtl/timing_fsm.sv - BANKGROUPS x BANKSPERGROUP array of DRAM bank timing FSMs (ROWCLONE_EN)
module timing_fsm
    import timing_fsm_pkg::*;
#(
    parameter int BGWIDTH = 2,
    parameter int BAWIDTH = 2,
    parameter int BL      = DEF_BL,
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_RFC   = DEF_T_RFC,
    parameter int T_WR    = DEF_T_WR,
    localparam int BGW           = (BGWIDTH > 0) ? BGWIDTH : 1,
    localparam int BANKGROUPS    = 2 ** BGWIDTH,
    localparam int BANKSPERGROUP = 2 ** BAWIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BGW-1:0]     bg,
    input  logic [BAWIDTH-1:0] ba,
    input  logic               ACT,
    input  logic               BST,
    input  logic               CFG,
    input  logic               CKEH,
    input  logic               CKEL,
    input  logic               DPD,
    input  logic               DPDX,
    input  logic               MRR,
    input  logic               MRW,
    input  logic               PD,
    input  logic               PDX,
    input  logic               PR,
    input  logic               PRA,
    input  logic               RD,
    input  logic               RDA,
    input  logic               REF,
    input  logic               SRF,
    input  logic               WR,
    input  logic               WRA,
    output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][4:0] BankFSM
);

    logic all_idle;
    // Mode-register and config strobes never move a bank.
    logic unused_cmds;
    assign unused_cmds = &{1'b0, MRR, MRW, CFG};

    always_comb begin
        all_idle = 1'b1;
        for (int g = 0; g < BANKGROUPS; g++)
            for (int b = 0; b < BANKSPERGROUP; b++)
                if (BankFSM[g][b] != ST_IDLE) all_idle = 1'b0;
    end

    for (genvar g = 0; g < BANKGROUPS; g++) begin : g_group
        for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
            logic               hit;
            logic [NUM_CMD-1:0] req;
            bank_state_t        st;

            assign hit = ((BGWIDTH == 0) || (bg == BGW'(g))) && (ba == BAWIDTH'(b));

            always_comb begin
                req           = '0;
                req[CMD_PRA]  = PRA;
                req[CMD_PR]   = PR  & hit;
                req[CMD_BST]  = BST & hit;
                req[CMD_RDA]  = RDA & hit;
                req[CMD_RD]   = RD  & hit;
                req[CMD_WRA]  = WRA & hit;
                req[CMD_WR]   = WR  & hit;
                req[CMD_ACT]  = ACT & hit;
                req[CMD_REF]  = REF;
                req[CMD_SRF]  = SRF;
                req[CMD_PD]   = PD | CKEL;
                req[CMD_PDX]  = PDX;
                req[CMD_CKEH] = CKEH;
                req[CMD_DPD]  = DPD;
                req[CMD_DPDX] = DPDX;
            end

            bank_fsm #(
                .BL(BL), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_WR(T_WR)
            ) u_bank (
                .clk      (clk),
                .reset    (reset),
                .req      (req),
                .all_idle (all_idle),
                .state    (st)
            );

            assign BankFSM[g][b] = st;
        end
    end

endmodule

// File: tb/tb_timing_fsm.sv
// tb/tb_timing_fsm.sv - self-checking bench for timing_fsm against a cycle-level bank model
module tb_timing_fsm;

    localparam int K_ACT = 0,  K_BST = 1,  K_CFG = 2,  K_CKEH = 3,  K_CKEL = 4,  K_DPD = 5;
    localparam int K_DPDX = 6, K_MRR = 7,  K_MRW = 8,  K_PD = 9,    K_PDX = 10,  K_PR = 11;
    localparam int K_PRA = 12, K_RD = 13,  K_RDA = 14, K_REF = 15,  K_SRF = 16,  K_WR = 17;
    localparam int K_WRA = 18;
    localparam int B = 5;  // bank [1][1]

`ifdef ROWCLONE_EN
    localparam bit ROWCLONE = 1'b1;
`else
    localparam bit ROWCLONE = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           bg = '0;
    logic [1:0]           ba = '0;
    logic [18:0]          cmds = '0;
    logic [3:0][3:0][4:0] bank_fsm;
    logic [79:0]          flat;
    logic [63:0]          mbank [16];
    int                   errors = 0;
    int                   checks = 0;

    assign flat = bank_fsm;

    always #5 clk = ~clk;

    timing_fsm dut (
        .clk(clk), .reset(rst), .bg(bg), .ba(ba),
        .ACT(cmds[K_ACT]), .BST(cmds[K_BST]), .CFG(cmds[K_CFG]), .CKEH(cmds[K_CKEH]),
        .CKEL(cmds[K_CKEL]), .DPD(cmds[K_DPD]), .DPDX(cmds[K_DPDX]), .MRR(cmds[K_MRR]),
        .MRW(cmds[K_MRW]), .PD(cmds[K_PD]), .PDX(cmds[K_PDX]), .PR(cmds[K_PR]),
        .PRA(cmds[K_PRA]), .RD(cmds[K_RD]), .RDA(cmds[K_RDA]), .REF(cmds[K_REF]),
        .SRF(cmds[K_SRF]), .WR(cmds[K_WR]), .WRA(cmds[K_WRA]),
        .BankFSM(bank_fsm)
    );

    function automatic int dur(input int s);
        case (s)
            1: return 15;
            3, 4: return 8;
            5, 6: return 14;
            7: return 16;
            8: return 34;
            default: return 0;
        endcase
    endfunction

    function automatic int follow(input int s);
        case (s)
            1, 3, 5: return 2;
            4, 6: return 7;
            default: return 0;
        endcase
    endfunction

    // Model state: {state, cycles left in the current timed state}.
    function automatic logic [63:0] model_step(input int s, input int l, input bit hit,
                                               input bit allid, input logic [18:0] c);
        int ns, nl, t;
        ns = s; nl = l; t = -1;
        if (dur(s) > 0 && l == 1) begin
            ns = follow(s); nl = dur(ns);
        end else if (s > 12) begin
            ns = 0; nl = 0;
        end else begin
            if (dur(s) > 0) nl = l - 1;
            if (c[K_PRA] && s == 2) t = 7;
            else if (hit && c[K_PR] && s == 2) t = 7;
            else if (hit && c[K_BST] && (s == 3 || s == 5)) t = 2;
            else if (hit && c[K_RDA] && s == 2) t = 4;
            else if (hit && c[K_RD] && s == 2) t = 3;
            else if (hit && c[K_WRA] && s == 2) t = 6;
            else if (hit && c[K_WR] && s == 2) t = 5;
            else if (hit && c[K_ACT] && (s == 0 || (ROWCLONE && (s == 2 || s == 6)))) t = 1;
            else if (c[K_REF] && allid) t = 8;
            else if (c[K_SRF] && allid) t = 11;
            else if ((c[K_PD] || c[K_CKEL]) && (s == 0 || s == 2)) t = (s == 0) ? 9 : 10;
            else if (c[K_PDX] && (s == 9 || s == 10)) t = (s == 9) ? 0 : 2;
            else if (c[K_CKEH] && s == 11) t = 0;
            else if (c[K_DPD] && allid) t = 12;
            else if (c[K_DPDX] && s == 12) t = 0;
            if (t >= 0) begin ns = t; nl = dur(t); end
        end
        return {32'(ns), 32'(nl)};
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < 16; i++) if (mbank[i][63:32] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [79:0] model_vec();
        logic [79:0] v;
        for (int i = 0; i < 16; i++) v[i*5 +: 5] = mbank[i][36:32];
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mbank[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                mbank[i] <= model_step(int'(mbank[i][63:32]), int'(mbank[i][31:0]),
                                       (int'(bg) == i / 4) && (int'(ba) == i % 4),
                                       model_idle(), cmds);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %020h expected %020h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst) chk_vec("model", flat, model_vec());

    function automatic int cur(input int i);
        return int'(flat[i*5 +: 5]);
    endfunction

    function automatic logic [79:0] fill(input int code);
        logic [79:0] v;
        for (int i = 0; i < 16; i++) v[i*5 +: 5] = 5'(code);
        return v;
    endfunction

    function automatic logic [79:0] with_bank(input logic [79:0] v, input int i, input int code);
        logic [79:0] r;
        r = v;
        r[i*5 +: 5] = 5'(code);
        return r;
    endfunction

    function automatic logic [18:0] m(input int k);
        return 19'(1) << k;
    endfunction

    task automatic issue(input logic [18:0] c, input int g, input int b);
        bg = 2'(g); ba = 2'(b); cmds = c;
        @(negedge clk);
        cmds = '0;
    endtask

    task automatic hold(input string name, input int code, input int cycles);
        int n;
        n = 0;
        while (cur(B) == code && n < 200) begin n++; @(negedge clk); end
        chk(name, n, cycles);
    endtask

    task automatic wait_state(input int code);
        int n;
        n = 0;
        while (cur(B) != code && n < 200) begin n++; @(negedge clk); end
        chk("wait_state", cur(B), code);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_vec("reset_all_idle", flat, '0);
        rst = 1'b0;
        @(negedge clk);

        issue(m(K_ACT), 1, 1);
        hold("act_len", 1, 15);
        chk_vec("act_done", flat, with_bank('0, B, 2));

        issue(m(K_WR), 1, 1);
        hold("wr_len", 5, 14);
        chk("wr_done", cur(B), 2);
        issue(m(K_PR), 1, 1);
        hold("pr_len", 7, 16);
        chk("pr_done", cur(B), 0);

        issue(m(K_REF), 0, 0);
        chk_vec("ref_all", flat, fill(8));
        hold("ref_len", 8, 34);
        chk_vec("ref_done", flat, '0);

        issue(m(K_ACT), 1, 1);
        hold("act_len2", 1, 15);
        issue(m(K_REF), 0, 0);
        chk_vec("ref_ignored", flat, with_bank('0, B, 2));

        issue(m(K_RD), 1, 1);
        hold("rd_len", 3, 8);
        chk("rd_done", cur(B), 2);
        issue(m(K_RDA), 1, 1);
        hold("rda_len", 4, 8);
        hold("rda_pre_len", 7, 16);
        chk("rda_done", cur(B), 0);

        issue(m(K_ACT), 1, 1);
        hold("act_len3", 1, 15);
        issue(m(K_WRA), 1, 1);
        hold("wra_len", 6, 14);
        hold("wra_pre_len", 7, 16);
        chk("wra_done", cur(B), 0);

        issue(m(K_RD), 1, 1);
        chk("rd_in_idle", cur(B), 0);

        issue(m(K_ACT), 1, 1);
        wait_state(2);
        issue(m(K_PR) | m(K_RD), 1, 1);
        chk("pr_beats_rd", cur(B), 7);
        wait_state(0);

        issue(m(K_ACT), 1, 1);
        wait_state(2);
        issue(m(K_ACT), 1, 1);
        chk("act_in_active", cur(B), ROWCLONE ? 1 : 2);
        wait_state(2);

        issue(m(K_RD), 1, 1);
        repeat (3) @(negedge clk);
        issue(m(K_BST), 1, 1);
        chk("bst_stops_read", cur(B), 2);

        issue(m(K_PD), 0, 0);
        chk_vec("pd_mixed", flat, with_bank(fill(9), B, 10));
        issue(m(K_PDX), 0, 0);
        chk_vec("pdx_mixed", flat, with_bank('0, B, 2));
        issue(m(K_PR), 1, 1);
        wait_state(0);

        issue(m(K_SRF), 0, 0);
        chk_vec("srf_all", flat, fill(11));
        issue(m(K_CKEH), 0, 0);
        chk_vec("ckeh_all", flat, '0);
        issue(m(K_DPD) | m(K_MRW), 0, 0);
        chk_vec("dpd_all", flat, fill(12));
        issue(m(K_DPDX), 0, 0);
        chk_vec("dpdx_all", flat, '0);

        issue(m(K_ACT), 1, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", cur(B), 0);
        @(negedge clk);
        rst = 1'b0;
        chk_vec("after_reset", flat, '0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
